// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path.
// Glyphs are active low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [MAX_DIGITS-1:0] an_off();
        return '1;
    endfunction

    function automatic logic [MAX_DIGITS-1:0] an_on(
        input logic [2:0] sel
    );
        logic [MAX_DIGITS-1:0] a;
        a      = an_off();
        a[sel] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment glyph.
// Purely combinational table lookup.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = GLYPHS[value];

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit seven-segment scan multiplexer with guard time,
// frame-coherent latching, leading-zero blanking and blink.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD_CYCLES = 2000,
    parameter int BLINK_DIV    = 125
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] GUARD      = SW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_DIV - 1);

    logic [SW-1:0] slot_cnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    logic [4*N_DIGITS-1:0] f_digits;
    logic [N_DIGITS-1:0]   f_dp;
    logic [N_DIGITS-1:0]   f_en;
    logic [N_DIGITS-1:0]   f_blink;
    logic                  f_blz;

    logic slot_last;
    logic latch;
    logic frame_end;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign latch     = (idx == IDX_LAST) && (slot_cnt == '0);
    assign frame_end = (idx == '0) && slot_last;

    // On the latch cycle, look through to the inputs so a zero
    // guard time still shows the new frame from its first cycle.
    logic [4*N_DIGITS-1:0] cur_digits;
    logic [N_DIGITS-1:0]   cur_dp;
    logic [N_DIGITS-1:0]   cur_en;
    logic [N_DIGITS-1:0]   cur_blink;
    logic                  cur_blz;

    assign cur_digits = latch ? digits_in  : f_digits;
    assign cur_dp     = latch ? dp_in      : f_dp;
    assign cur_en     = latch ? digit_en   : f_en;
    assign cur_blink  = latch ? blink_mask : f_blink;
    assign cur_blz    = latch ? blank_lz   : f_blz;

    logic [N_DIGITS-1:0] lz_blank;
    logic                lz_run;

    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run & (cur_digits[4*i +: 4] == 4'd0);
            if (i > 0) lz_blank[i] = cur_blz & lz_run;
        end
    end

    logic [3:0]            cur_digit;
    logic [6:0]            glyph;
    logic                  visible;
    logic [MAX_DIGITS-1:0] an_sel;

    assign cur_digit = cur_digits[4*idx +: 4];
    assign an_sel    = an_on(3'(idx));

    assign visible = (slot_cnt >= GUARD)
                  && cur_en[idx]
                  && !lz_blank[idx]
                  && !(cur_blink[idx] && blink_phase);

    seg_decode u_decode (
        .value (cur_digit),
        .seg   (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            idx         <= IDX_LAST;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            f_digits    <= '0;
            f_dp        <= '0;
            f_en        <= '0;
            f_blink     <= '0;
            f_blz       <= 1'b0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            if (slot_last) begin
                slot_cnt <= '0;
                idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (latch) begin
                f_digits <= digits_in;
                f_dp     <= dp_in;
                f_en     <= digit_en;
                f_blink  <= blink_mask;
                f_blz    <= blank_lz;
            end

            if (frame_end) begin
                if (frame_cnt == BLINK_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (visible) begin
                an  <= an_sel[N_DIGITS-1:0];
                seg <= glyph;
                dp  <= ~cur_dp[idx];
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 8-cycle slots,
// 2-cycle guard, blink every 2 frames.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .N_DIGITS     (4),
        .SCAN_DIV     (8),
        .GUARD_CYCLES (2),
        .BLINK_DIV    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    typedef struct {
        logic [15:0]     d;
        logic [3:0]      dpi;
        logic [3:0]      en;
        logic            blz;
        logic [3:0][3:0] ea;
        logic [3:0][6:0] es;
        logic [3:0]      ed;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(
        input logic [15:0] d, input logic [3:0] dpi,
        input logic [3:0] en, input logic blz,
        input logic [15:0] ea, input logic [27:0] es,
        input logic [3:0] ed
    );
        vec_t v;
        v.d = d; v.dpi = dpi; v.en = en; v.blz = blz;
        v.ea = ea; v.es = es; v.ed = ed;
        return v;
    endfunction

    task automatic chk(
        input string name, input logic [3:0] ea,
        input logic [6:0] es, input logic ed
    );
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            errors++;
            $display("FAIL %s: an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     name, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        adv(3);
        chk("reset", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One full 8-cycle slot: two dark guard cycles, then lit.
    task automatic check_slot(
        input string name, input logic [3:0] ea,
        input logic [6:0] es, input logic ed
    );
        adv(1);
        chk({name, " gap0"}, 4'hF, 7'h7F, 1'b1);
        adv(1);
        chk({name, " gap1"}, 4'hF, 7'h7F, 1'b1);
        adv(1);
        chk({name, " first"}, ea, es, ed);
        adv(5);
        chk({name, " last"}, ea, es, ed);
    endtask

    initial begin
        vecs[0] = mk(16'h1234, 4'h0, 4'hF, 1'b0,
                     {4'h7, 4'hB, 4'hD, 4'hE},
                     {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
        vecs[1] = mk(16'h0040, 4'h0, 4'hF, 1'b1,
                     {4'hF, 4'hF, 4'hD, 4'hE},
                     {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'hF);
        vecs[2] = mk(16'h0000, 4'h0, 4'hF, 1'b1,
                     {4'hF, 4'hF, 4'hF, 4'hE},
                     {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);
        vecs[3] = mk(16'h0000, 4'h0, 4'hF, 1'b0,
                     {4'h7, 4'hB, 4'hD, 4'hE},
                     {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
        vecs[4] = mk(16'h1234, 4'h4, 4'hF, 1'b0,
                     {4'h7, 4'hB, 4'hD, 4'hE},
                     {7'h79, 7'h24, 7'h30, 7'h19}, 4'hB);
        vecs[5] = mk(16'hEF09, 4'h4, 4'hB, 1'b0,
                     {4'h7, 4'hF, 4'hD, 4'hE},
                     {7'h06, 7'h7F, 7'h40, 7'h10}, 4'hF);
        vecs[6] = mk(16'h0A0B, 4'h0, 4'hF, 1'b1,
                     {4'hF, 4'hB, 4'hD, 4'hE},
                     {7'h7F, 7'h08, 7'h40, 7'h03}, 4'hF);
        vecs[7] = mk(16'h8000, 4'h0, 4'h7, 1'b1,
                     {4'hF, 4'hB, 4'hD, 4'hE},
                     {7'h7F, 7'h40, 7'h40, 7'h40}, 4'hF);
        vecs[8] = mk(16'hC5D7, 4'h0, 4'hF, 1'b1,
                     {4'h7, 4'hB, 4'hD, 4'hE},
                     {7'h46, 7'h12, 7'h21, 7'h78}, 4'hF);
        vecs[9] = mk(16'h3F6A, 4'h0, 4'hF, 1'b0,
                     {4'h7, 4'hB, 4'hD, 4'hE},
                     {7'h30, 7'h0E, 7'h02, 7'h08}, 4'hF);

        for (int v = 0; v < 10; v++) begin
            digits_in  = vecs[v].d;
            dp_in      = vecs[v].dpi;
            digit_en   = vecs[v].en;
            blink_mask = 4'h0;
            blank_lz   = vecs[v].blz;
            do_reset();
            for (int i = 3; i >= 0; i--)
                check_slot($sformatf("v%0d d%0d", v, i),
                           vecs[v].ea[i], vecs[v].es[i],
                           vecs[v].ed[i]);
        end

        // Mid-frame input change waits for the next frame latch.
        digits_in = 16'h1234; dp_in = 4'h0;
        digit_en = 4'hF; blank_lz = 1'b0;
        do_reset();
        check_slot("mid d3", 4'h7, 7'h79, 1'b1);
        adv(3);
        chk("mid d2 first", 4'hB, 7'h24, 1'b1);
        digits_in = 16'h5678;
        adv(5);
        chk("mid d2 last", 4'hB, 7'h24, 1'b1);
        check_slot("mid d1", 4'hD, 7'h30, 1'b1);
        check_slot("mid d0", 4'hE, 7'h19, 1'b1);
        check_slot("new d3", 4'h7, 7'h12, 1'b1);
        check_slot("new d2", 4'hB, 7'h02, 1'b1);
        check_slot("new d1", 4'hD, 7'h78, 1'b1);
        check_slot("new d0", 4'hE, 7'h00, 1'b1);

        // Blink on digit 0 plus a decimal point on digit 2.
        digits_in = 16'h1234; dp_in = 4'b0100;
        blink_mask = 4'b0001;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            check_slot($sformatf("blk f%0d d3", f), 4'h7, 7'h79, 1'b1);
            check_slot($sformatf("blk f%0d d2", f), 4'hB, 7'h24, 1'b0);
            check_slot($sformatf("blk f%0d d1", f), 4'hD, 7'h30, 1'b1);
            if (f == 2 || f == 3)
                check_slot($sformatf("blk f%0d d0", f),
                           4'hF, 7'h7F, 1'b1);
            else
                check_slot($sformatf("blk f%0d d0", f),
                           4'hE, 7'h19, 1'b1);
        end

        // Reset pulse in digit 1's slot restarts the scan.
        dp_in = 4'h0; blink_mask = 4'h0;
        digits_in = 16'h1234;
        do_reset();
        check_slot("rst d3", 4'h7, 7'h79, 1'b1);
        check_slot("rst d2", 4'hB, 7'h24, 1'b1);
        adv(4);
        chk("rst d1 lit", 4'hD, 7'h30, 1'b1);
        digits_in = 16'h9876;
        @(negedge clk);
        reset = 1'b1;
        adv(1);
        chk("rst pulse", 4'hF, 7'h7F, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        check_slot("post d3", 4'h7, 7'h10, 1'b1);
        check_slot("post d2", 4'hB, 7'h00, 1'b1);
        check_slot("post d1", 4'hD, 7'h78, 1'b1);
        check_slot("post d0", 4'hE, 7'h02, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
